// File: rtl/hamming_scrubber_pkg.sv
// Shared Hamming geometry and syndrome helpers for the scrubber and the future decoder.
// Parity bits occupy the 1-based power-of-two positions; data fills the rest in order.
package hamming_scrubber_pkg;
    localparam int MAX_BLOCK_WIDTH  = 64;
    localparam int MAX_PARITY_WIDTH = 7;

    // Smallest p with 2**p >= data_width + p + 1.
    function automatic int calc_parity_width(input int data_width);
        int p;
        p = 0;
        for (int k = MAX_PARITY_WIDTH; k >= 1; k--) begin
            if ((1 << k) >= data_width + k + 1) p = k;
        end
        return p;
    endfunction

    function automatic int calc_block_width(input int data_width);
        return data_width + calc_parity_width(data_width);
    endfunction

    // XOR of the 1-based positions of all set bits equals the per-parity-index XOR syndrome.
    function automatic logic [MAX_PARITY_WIDTH-1:0] calc_syndrome(
        input logic [MAX_BLOCK_WIDTH-1:0] block,
        input int                         block_width
    );
        logic [MAX_PARITY_WIDTH-1:0] syndrome;
        syndrome = '0;
        for (int i = 0; i < MAX_BLOCK_WIDTH; i++) begin
            if (i < block_width && block[i]) syndrome = syndrome ^ MAX_PARITY_WIDTH'(i + 1);
        end
        return syndrome;
    endfunction
endpackage

// File: rtl/hamming_scrubber_if.sv
// Shared memory port between the scrubber (master) and the protected memory (slave).
interface hamming_scrubber_if #(
    parameter int ADDR_WIDTH  = 4,
    parameter int BLOCK_WIDTH = 12
);
    logic                   mem_request;
    logic                   mem_grant;
    logic                   mem_read_enable;
    logic                   mem_write_enable;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic [BLOCK_WIDTH-1:0] mem_write_block;
    logic [BLOCK_WIDTH-1:0] mem_read_block;

    modport master (
        output mem_request, mem_read_enable, mem_write_enable, mem_address, mem_write_block,
        input  mem_grant, mem_read_block
    );

    modport slave (
        input  mem_request, mem_read_enable, mem_write_enable, mem_address, mem_write_block,
        output mem_grant, mem_read_block
    );
endinterface

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome of one block; zero means the block is a valid codeword.
module hamming_syndrome
    import hamming_scrubber_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    localparam int PARITY_WIDTH = calc_parity_width(DATA_WIDTH),
    localparam int BLOCK_WIDTH  = DATA_WIDTH + PARITY_WIDTH
) (
    input  logic [BLOCK_WIDTH-1:0]  block,
    output logic [PARITY_WIDTH-1:0] syndrome
);
    assign syndrome = PARITY_WIDTH'(calc_syndrome(MAX_BLOCK_WIDTH'(block), BLOCK_WIDTH));
endmodule

// File: rtl/hamming_scrubber.sv
// Background memory scrubber: periodically reads each word, fixes single-bit errors by
// writing the corrected block back, and flags syndromes that point past the block.
module hamming_scrubber
    import hamming_scrubber_pkg::*;
#(
    parameter  int DATA_WIDTH     = 8,
    parameter  int DEPTH          = 16,
    parameter  int SCRUB_INTERVAL = 1024,
    localparam int ADDR_WIDTH     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PARITY_WIDTH   = calc_parity_width(DATA_WIDTH),
    localparam int BLOCK_WIDTH    = DATA_WIDTH + PARITY_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    hamming_scrubber_if.master    mem,
    output logic                  busy,
    output logic                  corrected,
    output logic                  uncorrectable,
    output logic [ADDR_WIDTH-1:0] error_address,
    output logic [15:0]           corrected_count,
    output logic                  pass_done
);
    typedef enum logic [2:0] {IDLE, WAIT, READ, CHECK, WRITEBACK} state_t;

    localparam int                    CNT_WIDTH = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    state_t                  next_state;
    logic [CNT_WIDTH-1:0]    interval_cnt;
    logic [ADDR_WIDTH-1:0]   address;
    logic [ADDR_WIDTH-1:0]   next_address;
    logic                    at_last;
    logic [BLOCK_WIDTH-1:0]  fixed_block;
    logic [PARITY_WIDTH-1:0] syndrome;
    logic                    syndrome_zero;
    logic                    syndrome_in_range;

    hamming_syndrome #(.DATA_WIDTH(DATA_WIDTH)) u_syndrome (
        .block    (mem.mem_read_block),
        .syndrome (syndrome)
    );

    assign syndrome_zero     = (syndrome == '0);
    assign syndrome_in_range = (int'(syndrome) <= BLOCK_WIDTH);
    assign at_last           = (address == ADDR_LAST);
    assign next_address      = at_last ? '0 : address + 1'b1;
    assign mem.mem_address   = address;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (enable) next_state = WAIT;
            WAIT: begin
                if (!enable)                       next_state = IDLE;
                else if (interval_cnt == CNT_LAST) next_state = READ;
            end
            READ: begin
                if (!enable)            next_state = IDLE;
                else if (mem.mem_grant) next_state = CHECK;
            end
            CHECK:     next_state = (!syndrome_zero && syndrome_in_range) ? WRITEBACK : WAIT;
            WRITEBACK: if (mem.mem_grant) next_state = WAIT;
            default:   next_state = IDLE;
        endcase
    end

    // The read request is gated by enable so an abort never overlaps a grant.
    always_comb begin
        mem.mem_request      = 1'b0;
        mem.mem_read_enable  = 1'b0;
        mem.mem_write_enable = 1'b0;
        mem.mem_write_block  = '0;
        busy                 = (state != IDLE) && (state != WAIT);
        case (state)
            READ: begin
                mem.mem_request     = enable;
                mem.mem_read_enable = enable;
            end
            WRITEBACK: begin
                mem.mem_request      = 1'b1;
                mem.mem_write_enable = 1'b1;
                mem.mem_write_block  = fixed_block;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            interval_cnt    <= '0;
            address         <= '0;
            fixed_block     <= '0;
            error_address   <= '0;
            corrected_count <= '0;
            corrected       <= 1'b0;
            uncorrectable   <= 1'b0;
            pass_done       <= 1'b0;
        end else begin
            corrected     <= 1'b0;
            uncorrectable <= 1'b0;
            pass_done     <= 1'b0;
            case (state)
                IDLE: interval_cnt <= '0;
                WAIT: interval_cnt <= (interval_cnt == CNT_LAST) ? '0 : interval_cnt + 1'b1;
                CHECK: begin
                    interval_cnt <= '0;
                    if (!syndrome_zero && syndrome_in_range) begin
                        fixed_block <= mem.mem_read_block ^ (BLOCK_WIDTH'(1) << (syndrome - 1'b1));
                    end else begin
                        if (!syndrome_zero) begin
                            uncorrectable <= 1'b1;
                            error_address <= address;
                        end
                        address   <= next_address;
                        pass_done <= at_last;
                    end
                end
                WRITEBACK: begin
                    if (mem.mem_grant) begin
                        corrected     <= 1'b1;
                        error_address <= address;
                        if (corrected_count != 16'hFFFF) corrected_count <= corrected_count + 1'b1;
                        address   <= next_address;
                        pass_done <= at_last;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_scrubber.sv
// Directed bench for hamming_scrubber (DATA_WIDTH=8, DEPTH=4, SCRUB_INTERVAL=4) with a
// behavioural single-port memory whose read data returns one cycle after a granted read.
module tb_hamming_scrubber;
    localparam logic [11:0] WORD_A5 = 12'hA27;
    localparam logic [11:0] WORD_3C = 12'h362;

    logic        clock;
    logic        resetn;
    logic        enable;
    logic        grant_all;
    logic        grant_read_only;
    logic        busy;
    logic        corrected;
    logic        uncorrectable;
    logic [1:0]  error_address;
    logic [15:0] corrected_count;
    logic        pass_done;

    logic        inject_en   = 1'b0;
    logic [1:0]  inject_addr = '0;
    logic [11:0] inject_data = '0;
    logic [11:0] read_block  = '0;
    logic [11:0] mem_words [0:3];
    int          read_cycles [0:7];
    int          cycle           = 0;
    int          read_count      = 0;
    int          write_count     = 0;
    int          pass_count      = 0;
    int          rule_violations = 0;
    logic [1:0]  last_read_addr  = '0;
    logic [1:0]  last_write_addr = '0;
    logic [11:0] last_write_data = '0;

    int checks = 0;
    int errors = 0;

    hamming_scrubber_if #(.ADDR_WIDTH(2), .BLOCK_WIDTH(12)) bus ();

    assign bus.mem_grant      = grant_all | (grant_read_only & bus.mem_read_enable);
    assign bus.mem_read_block = read_block;

    hamming_scrubber #(.DATA_WIDTH(8), .DEPTH(4), .SCRUB_INTERVAL(4)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .enable          (enable),
        .mem             (bus),
        .busy            (busy),
        .corrected       (corrected),
        .uncorrectable   (uncorrectable),
        .error_address   (error_address),
        .corrected_count (corrected_count),
        .pass_done       (pass_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model plus bus-rule monitor.
    always @(posedge clock) begin
        cycle <= cycle + 1;
        if (inject_en) mem_words[inject_addr] <= inject_data;
        if (bus.mem_request && bus.mem_grant) begin
            if (bus.mem_read_enable) begin
                read_block     <= mem_words[bus.mem_address];
                read_count     <= read_count + 1;
                last_read_addr <= bus.mem_address;
                if (read_count < 8) read_cycles[read_count] <= cycle;
            end
            if (bus.mem_write_enable) begin
                mem_words[bus.mem_address] <= bus.mem_write_block;
                write_count     <= write_count + 1;
                last_write_addr <= bus.mem_address;
                last_write_data <= bus.mem_write_block;
            end
        end
        if ((bus.mem_read_enable && bus.mem_write_enable) ||
            (!bus.mem_request && (bus.mem_read_enable || bus.mem_write_enable)))
            rule_violations <= rule_violations + 1;
        if (pass_done) pass_count <= pass_count + 1;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic g_all, input logic g_rd);
        @(negedge clock);
        enable          = en;
        grant_all       = g_all;
        grant_read_only = g_rd;
    endtask

    task automatic load_word(input logic [1:0] addr, input logic [11:0] data);
        @(negedge clock);
        inject_en   = 1'b1;
        inject_addr = addr;
        inject_data = data;
        @(negedge clock);
        inject_en = 1'b0;
    endtask

    initial begin
        int timeout;
        int reads_before;
        int writes_before;

        resetn          = 1'b0;
        enable          = 1'b0;
        grant_all       = 1'b1;
        grant_read_only = 1'b0;
        load_word(2'd0, WORD_A5);
        load_word(2'd1, WORD_3C);
        load_word(2'd2, WORD_A5);
        load_word(2'd3, 12'h000);
        repeat (2) @(negedge clock);

        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_request", 32'(bus.mem_request), 32'd0);
        check_output("reset_rw", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
        check_output("reset_count", 32'(corrected_count), 32'd0);
        check_output("reset_pulses", 32'({corrected, uncorrectable, pass_done}), 32'd0);

        $display("[TB] clean pass");
        resetn = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        timeout = 0;
        while (pass_count < 1 && timeout < 300) begin
            @(negedge clock);
            timeout++;
        end
        check_output("clean_pass_done", 32'(pass_count), 32'd1);
        check_output("clean_reads", 32'(read_count), 32'd4);
        check_output("clean_period_a", 32'(read_cycles[1] - read_cycles[0]), 32'd6);
        check_output("clean_period_b", 32'(read_cycles[3] - read_cycles[2]), 32'd6);
        check_output("clean_writes", 32'(write_count), 32'd0);
        check_output("clean_count", 32'(corrected_count), 32'd0);

        $display("[TB] single-bit error at word 2");
        load_word(2'd2, 12'hA37);
        timeout = 0;
        while (!corrected && timeout < 200) begin
            @(negedge clock);
            timeout++;
        end
        check_output("fix_pulse", 32'(corrected), 32'd1);
        check_output("fix_error_addr", 32'(error_address), 32'd2);
        check_output("fix_count", 32'(corrected_count), 32'd1);
        check_output("fix_writes", 32'(write_count), 32'd1);
        check_output("fix_write_addr", 32'(last_write_addr), 32'd2);
        check_output("fix_write_data", 32'(last_write_data), 32'hA27);
        @(negedge clock);
        check_output("fix_pulse_width", 32'(corrected), 32'd0);

        $display("[TB] double-bit error at word 1");
        load_word(2'd1, 12'hB63);
        timeout = 0;
        while (!uncorrectable && timeout < 200) begin
            @(negedge clock);
            timeout++;
        end
        check_output("unc_pulse", 32'(uncorrectable), 32'd1);
        check_output("unc_error_addr", 32'(error_address), 32'd1);
        check_output("unc_writes", 32'(write_count), 32'd1);
        check_output("unc_count", 32'(corrected_count), 32'd1);
        check_output("unc_word_kept", 32'(mem_words[1]), 32'hB63);

        $display("[TB] grant withheld during read");
        apply_stimulus(1'b1, 1'b0, 1'b0);
        timeout = 0;
        while (!bus.mem_request && timeout < 50) begin
            @(negedge clock);
            timeout++;
        end
        check_output("stall_request", 32'(bus.mem_request), 32'd1);
        reads_before = read_count;
        repeat (20) @(negedge clock);
        check_output("stall_holding", 32'({bus.mem_request, bus.mem_read_enable, busy}), 32'd7);
        enable = 1'b0;
        @(negedge clock);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_request", 32'(bus.mem_request), 32'd0);
        repeat (3) @(negedge clock);
        check_output("abort_no_read", 32'(read_count), 32'(reads_before));
        check_output("abort_idle", 32'(busy), 32'd0);

        $display("[TB] reset during writeback");
        load_word(2'd0, 12'hA26);
        load_word(2'd1, 12'h366);
        load_word(2'd2, 12'hA37);
        load_word(2'd3, 12'h100);
        writes_before = write_count;
        apply_stimulus(1'b1, 1'b0, 1'b1);
        timeout = 0;
        while (!bus.mem_write_enable && timeout < 100) begin
            @(negedge clock);
            timeout++;
        end
        check_output("wb_reached", 32'(bus.mem_write_enable), 32'd1);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check_output("rst_async_bus", 32'({bus.mem_request, bus.mem_write_enable, bus.mem_read_enable}), 32'd0);
        check_output("rst_async_block", 32'(bus.mem_write_block), 32'd0);
        check_output("rst_async_busy", 32'(busy), 32'd0);
        check_output("rst_async_count", 32'(corrected_count), 32'd0);
        check_output("rst_async_addr", 32'(error_address), 32'd0);
        @(negedge clock);
        check_output("rst_write_dropped", 32'(write_count), 32'(writes_before));
        resetn = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        reads_before = read_count;
        timeout = 0;
        while (read_count == reads_before && timeout < 50) begin
            @(negedge clock);
            timeout++;
        end
        check_output("restart_read", 32'(read_count), 32'(reads_before + 1));
        check_output("restart_addr", 32'(last_read_addr), 32'd0);
        timeout = 0;
        while (!corrected && timeout < 50) begin
            @(negedge clock);
            timeout++;
        end
        check_output("restart_fix", 32'(corrected), 32'd1);
        check_output("restart_write_addr", 32'(last_write_addr), 32'd0);
        check_output("restart_write_data", 32'(last_write_data), 32'hA27);
        check_output("restart_count", 32'(corrected_count), 32'd1);
        check_output("restart_error_addr", 32'(error_address), 32'd0);

        check_output("bus_rules", 32'(rule_violations), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_scrubber.md
HAMMING_SCRUBBER -- requirements
Module: hamming_scrubber

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of each protected data word.
REQ-002 SHALL have parameter DEPTH, default 16, meaning number of memory words to scrub; address width = clog2(DEPTH).
REQ-003 SHALL have parameter SCRUB_INTERVAL, default 1024, meaning idle cycles between consecutive word scrubs; minimum 1.
REQ-004 SHALL derive PARITY_WIDTH and BLOCK_WIDTH = DATA_WIDTH + PARITY_WIDTH exactly as the team's Hamming encoder does, with the same block bit layout.
REQ-005 SHALL have port clock, input, 1, the single clock.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, run scrubbing while high.
REQ-008 SHALL have port mem_request, output, 1, request for the shared memory port.
REQ-009 SHALL have port mem_grant, input, 1, the memory access is performed in any cycle where mem_request and mem_grant are both high.
REQ-010 SHALL have ports mem_read_enable and mem_write_enable, each output, 1, the access type.
REQ-011 SHALL have port mem_address, output, clog2(DEPTH), the word address.
REQ-012 SHALL have port mem_write_block, output, BLOCK_WIDTH, the corrected block to write.
REQ-013 SHALL have port mem_read_block, input, BLOCK_WIDTH, read data, valid exactly one cycle after the granted read.
REQ-014 SHALL have ports busy, output, 1, high when the state is not IDLE or WAIT.
REQ-015 SHALL have ports corrected and uncorrectable, each output, 1, single-cycle event pulses.
REQ-016 SHALL have port error_address, output, clog2(DEPTH), the address of the last corrected or uncorrectable word.
REQ-017 SHALL have port corrected_count, output, 16, a saturating count of corrections.
REQ-018 SHALL have port pass_done, output, 1, a single-cycle pulse when the address wraps from DEPTH-1 to 0.

Function
REQ-019 SHALL implement states IDLE, WAIT, READ, CHECK and WRITEBACK.
REQ-020 IDLE: SHALL move to WAIT with the interval counter cleared when enable is high.
REQ-021 WAIT: SHALL count cycles and move to READ once SCRUB_INTERVAL cycles have elapsed; enable low returns to IDLE.
REQ-022 READ: SHALL hold mem_request=1, mem_read_enable=1 and mem_address=current address until granted, then go to CHECK; enable low before grant aborts to IDLE with no access.
REQ-023 CHECK: SHALL compute the syndrome as, for each parity index p, the XOR of all block bits whose 1-based position has bit p set, parity bits included.
REQ-024 CHECK, syndrome zero: SHALL advance the address and go to WAIT.
REQ-025 CHECK, syndrome in 1..BLOCK_WIDTH: SHALL register mem_read_block with bit (syndrome-1) inverted and go to WRITEBACK.
REQ-026 CHECK, syndrome > BLOCK_WIDTH (a padding position): SHALL pulse uncorrectable, update error_address, advance the address and go to WAIT; the word is not written.
REQ-027 WRITEBACK: SHALL hold mem_request=1, mem_write_enable=1 and mem_write_block=corrected block until granted; on grant it SHALL pulse corrected the next cycle, update error_address, increment corrected_count (saturating at 0xFFFF), advance the address and go to WAIT.
REQ-028 SHALL ignore enable in CHECK and WRITEBACK; the current word always completes, then enable low leads to IDLE from WAIT.
REQ-029 SHALL never assert mem_read_enable and mem_write_enable together; both SHALL be 0 whenever mem_request=0.
REQ-030 Address advance: SHALL wrap DEPTH-1 to 0 and pulse pass_done in the same cycle as the wrap.
REQ-031 Double-bit errors whose syndrome lands in range are miscorrected; this is accepted behaviour (SEC only, no DED).

Reset
REQ-032 On resetn low, SHALL asynchronously force state IDLE, address 0, interval counter 0, corrected_count 0, error_address 0, and all outputs 0.
REQ-033 Reset mid-WRITEBACK SHALL drop the write; memory contents are not guaranteed.

Structure
REQ-034 The Hamming width macros and the syndrome function SHALL live in the shared hamming header/package, with state enumeration local to the module.
REQ-035 Syndrome computation SHALL be one combinational sub-module, hamming_syndrome, reusable by the future decoder.

Verification (DATA_WIDTH=8, DEPTH=4, SCRUB_INTERVAL=4; BLOCK_WIDTH=12)
REQ-036 Clean memory with grant tied high -> one read every 6 cycles, no writes, pass_done once per 4 words, corrected_count stays 0.
REQ-037 Word 2 with block bit index 4 flipped -> syndrome 5, write of the original block to address 2, corrected pulse, error_address=2, count=1.
REQ-038 Word 1 with bit indices 0 and 11 flipped -> syndrome 13, uncorrectable pulse, error_address=1, no write issued.
REQ-039 Grant held low for 20 cycles during READ, then enable dropped -> no access performed, return to IDLE, busy=0.
REQ-040 resetn asserted during WRITEBACK -> all outputs 0 immediately; after release, scrubbing restarts at address 0.
